trace_packer: RTL and testbench

Parametrised successor of the trace/stream front end between the FPGA user logic and the trace-buffer memory port. In trace mode it samples 2**NTRACE_I trace lanes every DECIM_I+1 clocks. It packs the samples into WIDTH-bit words, records the trigger position and double-buffers completed words towards memory with overflow detection. In stream mode it double-buffers words fetched from memory and serialises them to the FPGA under a valid/read handshake.

---
 rtl/trace_packer_pkg.sv | 16 +
 rtl/trace_packer_decim_strobe.sv | 25 ++
 rtl/trace_packer.sv | 175 +++++++++++++++++
 tb/tb_trace_packer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_packer_pkg.sv
// Shared constants and types for the trace/stream packer.
package trb_pkg;

    localparam int unsigned WIDTH       = 32;
    localparam int unsigned MAX_TRACES  = 8;
    localparam int unsigned NTRACE_BITS = $clog2($clog2(MAX_TRACES) + 1);
    localparam int unsigned DECIM_BITS  = 8;

    typedef enum logic {
        ModeTrace  = 1'b0,
        ModeStream = 1'b1
    } mode_e;

    typedef logic [$clog2(WIDTH)-1:0] idx_t;

endpackage

// File: rtl/trace_packer_decim_strobe.sv
// Sample strobe generator: fires on the first cycle after reset, then every decim+1 cycles.
module decim_strobe #(
    parameter int unsigned DECIM_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic [DECIM_BITS-1:0] decim,
    output logic                  strobe
);

    logic [DECIM_BITS-1:0] cnt_q;

    // Qualified by reset so no sample is reported while the block is held in reset.
    assign strobe = en & rst_n & (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= strobe ? decim : cnt_q - 1'b1;
        end
    end

endmodule

// File: rtl/trace_packer.sv
// Trace sampler/packer towards memory and memory-to-FPGA stream serialiser, double-buffered.
module trace_packer #(
    parameter int unsigned WIDTH       = trb_pkg::WIDTH,
    parameter int unsigned MAX_TRACES  = trb_pkg::MAX_TRACES,
    parameter int unsigned NTRACE_BITS = $clog2($clog2(MAX_TRACES) + 1),
    parameter int unsigned DECIM_BITS  = trb_pkg::DECIM_BITS
) (
    input  logic                     FPGA_CLK_I,
    input  logic                     RST_NI,
    input  logic                     MODE_I,
    input  logic [NTRACE_BITS-1:0]   NTRACE_I,
    input  logic [DECIM_BITS-1:0]    DECIM_I,
    output logic [$clog2(WIDTH)-1:0] EVENT_POS_O,
    output logic                     TRG_EVENT_O,
    input  logic                     TRG_DELAYED_I,
    output logic                     OVERFLOW_O,
    input  logic [WIDTH-1:0]         DATA_I,
    output logic                     LOAD_REQUEST_O,
    input  logic                     LOAD_GRANT_I,
    output logic [WIDTH-1:0]         DATA_O,
    output logic                     STORE_O,
    input  logic                     STORE_PERM_I,
    input  logic                     FPGA_TRIG_I,
    input  logic [MAX_TRACES-1:0]    FPGA_TRACE_I,
    output logic                     FPGA_WRITE_VALID_O,
    input  logic                     FPGA_READ_I,
    output logic [MAX_TRACES-1:0]    FPGA_STREAM_O,
    output logic                     FPGA_DELAYED_TRIG_O
);
    import trb_pkg::mode_e;
    import trb_pkg::ModeTrace;
    import trb_pkg::ModeStream;

    localparam int unsigned IW     = $clog2(WIDTH);
    localparam int unsigned LOG_MT = $clog2(MAX_TRACES);

    mode_e                  mode;
    logic [NTRACE_BITS-1:0] ntr;
    logic [IW:0]            lanes;
    int unsigned            n_lanes;
    logic [IW-1:0]          idx_inc;
    logic                   wrap, strobe, store, req, gnt, rd, last_rd;

    logic [IW-1:0]    idx_q, idx_d, evpos_q, evpos_d;
    logic [WIDTH-1:0] asm_q, asm_d, hold_q, hold_d, out_q, out_d, pre_q, pre_d;
    logic             hold_full_q, hold_full_d, ovf_q, ovf_d, trg_q, trg_d, dly_q;
    logic             out_full_q, out_full_d, pre_full_q, pre_full_d;

    assign mode    = mode_e'(MODE_I);
    assign ntr     = (32'(NTRACE_I) > LOG_MT) ? NTRACE_BITS'(LOG_MT) : NTRACE_I;
    assign lanes   = (IW+1)'(1) << ntr;
    assign n_lanes = 32'(lanes);
    // idx is always a multiple of the lane count, so landing on 0 marks the last slice.
    assign idx_inc = idx_q + lanes[IW-1:0];
    assign wrap    = (idx_inc == '0);

    decim_strobe #(
        .DECIM_BITS(DECIM_BITS)
    ) u_decim (
        .clk   (FPGA_CLK_I),
        .rst_n (RST_NI),
        .en    (mode == ModeTrace),
        .decim (DECIM_I),
        .strobe(strobe)
    );

    assign store   = hold_full_q & STORE_PERM_I & (mode == ModeTrace);
    assign req     = ~pre_full_q & (mode == ModeStream);
    assign gnt     = LOAD_GRANT_I & req;
    assign rd      = FPGA_READ_I & out_full_q;
    assign last_rd = rd & wrap;

    always_comb begin
        idx_d       = idx_q;
        evpos_d     = evpos_q;
        asm_d       = asm_q;
        hold_d      = hold_q;
        hold_full_d = hold_full_q;
        ovf_d       = ovf_q;
        trg_d       = trg_q;
        out_d       = out_q;
        out_full_d  = out_full_q;
        pre_d       = pre_q;
        pre_full_d  = pre_full_q;
        if (mode == ModeTrace) begin
            if (strobe) begin
                for (int unsigned j = 0; j < MAX_TRACES; j++) begin
                    if (j < n_lanes) asm_d[idx_q + IW'(j)] = FPGA_TRACE_I[j];
                end
                idx_d = idx_inc;
                if (FPGA_TRIG_I && !trg_q) begin
                    trg_d   = 1'b1;
                    evpos_d = idx_q;
                end
            end
            if (strobe && wrap) begin
                // A store in the same cycle frees the holding register for the new word.
                if (!hold_full_q || store) begin
                    hold_d      = asm_d;
                    hold_full_d = 1'b1;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (store) begin
                hold_full_d = 1'b0;
            end
        end else begin
            if (rd) idx_d = idx_inc;
            if (gnt && (!out_full_q || last_rd)) begin
                out_d      = DATA_I;
                out_full_d = 1'b1;
            end else if (last_rd) begin
                if (pre_full_q) begin
                    out_d      = pre_q;
                    pre_full_d = 1'b0;
                end else begin
                    out_full_d = 1'b0;
                end
            end
            if (gnt && out_full_q && !last_rd) begin
                pre_d      = DATA_I;
                pre_full_d = 1'b1;
            end
        end
    end

    always_ff @(posedge FPGA_CLK_I or negedge RST_NI) begin
        if (!RST_NI) begin
            idx_q       <= '0;
            evpos_q     <= '0;
            asm_q       <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            ovf_q       <= 1'b0;
            trg_q       <= 1'b0;
            dly_q       <= 1'b0;
            out_q       <= '0;
            out_full_q  <= 1'b0;
            pre_q       <= '0;
            pre_full_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            evpos_q     <= evpos_d;
            asm_q       <= asm_d;
            hold_q      <= hold_d;
            hold_full_q <= hold_full_d;
            ovf_q       <= ovf_d;
            trg_q       <= trg_d;
            dly_q       <= TRG_DELAYED_I;
            out_q       <= out_d;
            out_full_q  <= out_full_d;
            pre_q       <= pre_d;
            pre_full_q  <= pre_full_d;
        end
    end

    always_comb begin
        FPGA_STREAM_O = '0;
        if (out_full_q) begin
            for (int unsigned j = 0; j < MAX_TRACES; j++) begin
                if (j < n_lanes) FPGA_STREAM_O[j] = out_q[idx_q + IW'(j)];
            end
        end
    end

    assign EVENT_POS_O         = evpos_q;
    assign TRG_EVENT_O         = trg_q;
    assign OVERFLOW_O          = ovf_q;
    assign DATA_O              = hold_q;
    assign STORE_O             = store;
    assign LOAD_REQUEST_O      = req;
    assign FPGA_WRITE_VALID_O  = strobe;
    assign FPGA_DELAYED_TRIG_O = (mode == ModeStream) ? out_full_q : dly_q;

endmodule

// File: tb/tb_trace_packer.sv
// Randomised scoreboard bench for trace_packer: trace packing/overflow and stream serialisation.
module tb_trace_packer;

    localparam int W  = 32;
    localparam int MT = 8;
    localparam int NB = 2;
    localparam int DB = 8;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          mode = 1'b0;
    logic [NB-1:0] ntrace = '0;
    logic [DB-1:0] decim = '0;
    logic [IW-1:0] event_pos;
    logic          trg_event, trg_delayed, overflow;
    logic [W-1:0]  data_in, data_out;
    logic          load_req, load_grant, store, store_perm, trig;
    logic [MT-1:0] trace_in, stream_out;
    logic          write_valid, fpga_read, delayed_trig;

    trace_packer #(
        .WIDTH      (W),
        .MAX_TRACES (MT),
        .NTRACE_BITS(NB),
        .DECIM_BITS (DB)
    ) dut (
        .FPGA_CLK_I         (clk),
        .RST_NI             (rst_n),
        .MODE_I             (mode),
        .NTRACE_I           (ntrace),
        .DECIM_I            (decim),
        .EVENT_POS_O        (event_pos),
        .TRG_EVENT_O        (trg_event),
        .TRG_DELAYED_I      (trg_delayed),
        .OVERFLOW_O         (overflow),
        .DATA_I             (data_in),
        .LOAD_REQUEST_O     (load_req),
        .LOAD_GRANT_I       (load_grant),
        .DATA_O             (data_out),
        .STORE_O            (store),
        .STORE_PERM_I       (store_perm),
        .FPGA_TRIG_I        (trig),
        .FPGA_TRACE_I       (trace_in),
        .FPGA_WRITE_VALID_O (write_valid),
        .FPGA_READ_I        (fpga_read),
        .FPGA_STREAM_O      (stream_out),
        .FPGA_DELAYED_TRIG_O(delayed_trig)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    logic [W-1:0]  exp_words[$];
    logic [MT-1:0] exp_slices[$];
    logic [W-1:0]  gq[$];
    bit            mon_stream;
    bit            sbits[$];

    // Reference model state (abstract: sample counts, bit queue, buffered word count)
    int            L, S, D, t_cycle, t_samples, words_done, n_buf, rem;
    bit            slot, ovf_exp, trg_exp, dly_prev;
    logic [IW-1:0] evpos_exp;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: pops an expected item whenever the DUT hands one over.
    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (!mon_stream && store) begin
                if (exp_words.size() == 0) check("unexpected_store", 1, 0);
                else check("store_data", data_out, exp_words.pop_front());
            end
            if (mon_stream && delayed_trig && fpga_read) begin
                if (exp_slices.size() == 0) check("unexpected_slice", 1, 0);
                else check("stream_slice", stream_out, exp_slices.pop_front());
            end
        end
    end

    task automatic apply_reset(input bit m, input int nt, input int dec);
        rst_n = 1'b0;
        mode = m; ntrace = NB'(nt); decim = DB'(dec);
        store_perm = 0; load_grant = 0; fpga_read = 0; trig = 0;
        trace_in = '0; trg_delayed = 0; data_in = '0;
        #1;
        check("rst_store", store, 0);
        check("rst_data_o", data_out, 0);
        check("rst_overflow", overflow, 0);
        check("rst_trg_event", trg_event, 0);
        check("rst_event_pos", event_pos, 0);
        check("rst_write_valid", write_valid, 0);
        check("rst_load_req", load_req, m);
        check("rst_stream", stream_out, 0);
        check("rst_delayed_trig", delayed_trig, 0);
        exp_words.delete(); exp_slices.delete(); gq.delete(); sbits.delete();
        L = 1 << ((nt > 3) ? 3 : nt); S = W / L; D = dec;
        t_cycle = 0; t_samples = 0; words_done = 0; n_buf = 0; rem = S;
        slot = 0; ovf_exp = 0; trg_exp = 0; dly_prev = 0; evpos_exp = '0;
        mon_stream = m;
        @(posedge clk);
        #2 rst_n = 1'b1;
    endtask

    // permsel: 0 always permitted, 1 blocked until three words completed, 2 random
    task automatic run_trace(input int ncyc, input int permsel, input int trig_at,
                             input bit use_pat, input logic [W-1:0] pat);
        logic [MT-1:0] lanes;
        logic [W-1:0]  w;
        bit            stb, tg, perm, st, done, dly_in;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check("overflow", overflow, ovf_exp);
            check("trg_event", trg_event, trg_exp);
            check("event_pos", event_pos, evpos_exp);
            check("delayed_trig", delayed_trig, dly_prev);
            stb = (t_cycle % (D + 1)) == 0;
            lanes = MT'($urandom);
            if (use_pat) for (int j = 0; j < L; j++) lanes[j] = pat[(t_samples * L + j) % W];
            if (stb) tg = (t_samples == trig_at) ||
                          (trig_at >= 0 && t_samples > trig_at && ($urandom % 2) == 1);
            else tg = ($urandom % 2) == 1;
            perm = (permsel == 0) ? 1'b1 :
                   (permsel == 1) ? (words_done >= 3) : (($urandom % 2) == 1);
            dly_in = ($urandom % 2) == 1;
            trace_in = lanes; trig = tg; store_perm = perm; trg_delayed = dly_in;
            #1;
            check("write_valid", write_valid, stb);
            check("store_strobe", store, slot && perm);
            check("trace_load_req", load_req, 0);
            check("trace_stream", stream_out, 0);
            st = slot && perm;
            done = 0;
            if (stb) begin
                if (tg && !trg_exp) begin
                    trg_exp = 1;
                    evpos_exp = IW'((t_samples * L) % W);
                end
                for (int j = 0; j < L; j++) sbits.push_back(lanes[j]);
                t_samples++;
                if (sbits.size() == W) begin
                    for (int i = 0; i < W; i++) w[i] = sbits[i];
                    sbits.delete();
                    done = 1;
                    words_done++;
                end
            end
            if (done) begin
                if (!slot || st) begin
                    exp_words.push_back(w);
                    slot = 1;
                end else begin
                    ovf_exp = 1;
                end
            end else if (st) begin
                slot = 0;
            end
            dly_prev = dly_in;
            t_cycle++;
        end
        @(negedge clk);
        store_perm = 0;
        #3;
        check("pending_words", exp_words.size(), slot ? 1 : 0);
    endtask

    task automatic run_stream(input int ncyc, input bit directed, input bit rd_rand);
        logic [W-1:0]  wd;
        logic [MT-1:0] sl;
        bit            rd, gn, rdv, acc;
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            check("stream_valid", delayed_trig, n_buf > 0);
            check("load_req", load_req, n_buf < 2);
            check("stream_store", store, 0);
            check("stream_write_valid", write_valid, 0);
            check("stream_trg_event", trg_event, 0);
            if (n_buf == 0) check("stream_idle_zero", stream_out, 0);
            rd = rd_rand ? (($urandom % 2) == 1) : 1'b1;
            if (directed) begin
                gn = gq.size() > 0;
                wd = gn ? gq[0] : W'($urandom);
            end else begin
                gn = ($urandom % 2) == 1;
                wd = W'($urandom);
            end
            fpga_read = rd; load_grant = gn; data_in = wd;
            trg_delayed = ($urandom % 2) == 1;
            #1;
            rdv = rd && n_buf > 0;
            acc = gn && n_buf < 2;
            if (rdv) begin
                rem--;
                if (rem == 0) begin
                    n_buf--;
                    rem = S;
                end
            end
            if (acc) begin
                n_buf++;
                for (int s = 0; s < S; s++) begin
                    sl = '0;
                    for (int j = 0; j < L; j++) sl[j] = wd[s * L + j];
                    exp_slices.push_back(sl);
                end
                if (directed) void'(gq.pop_front());
            end
        end
        @(negedge clk);
        fpga_read = 0; load_grant = 0;
        #3;
        check("pending_slices", exp_slices.size(), (n_buf == 0) ? 0 : (n_buf - 1) * S + rem);
    endtask

    initial begin
        // 2 lanes, pattern-driven word, trigger on sample 5
        apply_reset(0, 1, 0);
        run_trace(22, 0, 5, 1, 32'hA5C3_1E77);
        check("tp1_event_pos", event_pos, 10);
        check("tp1_trg_event", trg_event, 1);

        // 8 lanes, decimation 3; ends mid-word and resets there
        apply_reset(0, 3, 3);
        run_trace(70, 0, 2, 0, '0);

        // holding register blocked for three words
        apply_reset(0, 3, 0);
        run_trace(24, 1, -1, 0, '0);
        check("tp3_overflow", overflow, 1);

        apply_reset(0, 2, int'($urandom_range(0, 2)));
        run_trace(200, 2, int'($urandom_range(0, 20)), 0, '0);

        // stream: two directed words serialised one bit per clock
        apply_reset(1, 0, 0);
        gq.push_back(32'h1234_5678);
        gq.push_back(32'hDEAD_BEEF);
        run_stream(75, 1, 0);
        check("tp4_valid_low", delayed_trig, 0);

        // stream: random handshakes, mid-word reset, then again from idx 0
        apply_reset(1, 2, 0);
        run_stream(150, 0, 1);
        apply_reset(1, 2, 0);
        run_stream(100, 0, 1);

        // trace after a stream session
        apply_reset(0, 0, 1);
        run_trace(150, 2, 7, 0, '0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
